snes_controller_reader: RTL and testbench

Serial reader for the SNES game-pad port that produces the 12-bit active-low `controller_state` word consumed by the sprite/RGB logic. It periodically generates the pad's latch and clock waveforms, shifts in the 16 serial bits, and publishes the first 12 as a parallel word. It sits between the FPGA pins wired to the pad connector and every block that reacts to buttons.

---
 rtl/snes_pkg.sv | 34 +++
 rtl/snes_controller_reader_sync_2ff.sv | 21 ++
 rtl/snes_controller_reader.sv | 129 ++++++++++++
 tb/tb_snes_controller_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// Shared constants, button map and FSM state type for the SNES pad reader.
package snes_pkg;

    localparam int SNES_BITS = 16;
    localparam int STATE_W   = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } snes_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/snes_controller_reader_sync_2ff.sv
// Two-flop synchronizer for the pad data pin; idles high like the pad line.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_controller_reader.sv
// SNES pad serial reader: periodic latch/clock generation, 16-bit shift-in.
// Define SNES_SYNC_EN to pass snes_data through a two-flop synchronizer.
module snes_controller_reader
    import snes_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               snes_data,
    output logic               snes_latch,
    output logic               snes_clk,
    output logic [STATE_W-1:0] controller_state,
    output logic               state_valid
);

    localparam int CNT_W =
        $clog2(max3(LATCH_CYCLES, HALF_CYCLES, POLL_CYCLES));

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);

    snes_state_t          state;
    logic [CNT_W-1:0]     poll_cnt;
    logic [CNT_W-1:0]     phase;
    logic [4:0]           index;
    logic [3:0]           slot;
    logic [SNES_BITS-1:0] shadow;
    logic                 data_s;
    logic                 tick;

`ifdef SNES_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (snes_data),
        .q     (data_s)
    );
`else
    assign data_s = snes_data;
`endif

    assign tick = (poll_cnt == POLL_LAST);

    // Low phase n reads the bit shifted out by the rising edge of pulse n-1;
    // index 16 wraps to slot 15, the last serial bit.
    assign slot = index[3:0] - 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            phase            <= '0;
            index            <= '0;
            shadow           <= '1;
            snes_latch       <= 1'b0;
            snes_clk         <= 1'b1;
            controller_state <= '1;
            state_valid      <= 1'b0;
        end else begin
            state_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= LATCH;
                        snes_latch <= 1'b1;
                        phase      <= '0;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        shadow[0]  <= data_s;
                        snes_latch <= 1'b0;
                        snes_clk   <= 1'b0;
                        index      <= 5'd1;
                        phase      <= '0;
                        state      <= CLK_LOW;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (phase == HALF_LAST) begin
                        shadow[slot] <= data_s;
                        snes_clk     <= 1'b1;
                        phase        <= '0;
                        state        <= CLK_HIGH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (phase == HALF_LAST) begin
                        phase <= '0;
                        if (index == 5'd16) begin
                            state <= DONE;
                        end else begin
                            index    <= index + 5'd1;
                            snes_clk <= 1'b0;
                            state    <= CLK_LOW;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    controller_state <= shadow[STATE_W-1:0];
                    state_valid      <= 1'b1;
                    index            <= '0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed bench for snes_controller_reader with a behavioural SNES pad.
module tb_snes_controller_reader;

    localparam int L     = 6;
    localparam int H     = 3;
    localparam int P     = 200;
    localparam int P2    = 50;
    localparam int FRAME = L + 32 * H + 1;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        reset2 = 1'b1;

    logic        data1, latch1, sclk1, valid1;
    logic [11:0] state1;
    logic        data2, latch2, sclk2, valid2;
    logic [11:0] state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snes_controller_reader #(
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H),
        .POLL_CYCLES  (P)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .snes_data        (data1),
        .snes_latch       (latch1),
        .snes_clk         (sclk1),
        .controller_state (state1),
        .state_valid      (valid1)
    );

    snes_controller_reader #(
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H),
        .POLL_CYCLES  (P2)
    ) dut_fast (
        .clk              (clk),
        .reset            (reset2),
        .snes_data        (data2),
        .snes_latch       (latch2),
        .snes_clk         (sclk2),
        .controller_state (state2),
        .state_valid      (valid2)
    );

    // Pad model: latch reloads bit 0, each rising snes_clk shifts one bit.
    logic [15:0] pad1 = 16'hFFFF;
    logic [15:0] pad2 = 16'h0A5C;
    int idx1 = 0;
    int idx2 = 0;

    always @(posedge latch1 or posedge sclk1)
        if (latch1) idx1 = 0;
        else        idx1 = idx1 + 1;

    always @(posedge latch2 or posedge sclk2)
        if (latch2) idx2 = 0;
        else        idx2 = idx2 + 1;

    assign data1 = (idx1 < 16) ? pad1[idx1[3:0]] : 1'b1;
    assign data2 = (idx2 < 16) ? pad2[idx2[3:0]] : 1'b1;

    // Waveform monitors, sampled on the falling clock edge.
    logic latch1_q = 1'b0;
    logic latch2_q = 1'b0;
    int latch_run1 = 0, latch_w1 = 0;
    int lo_run1 = 0, pulses1 = 0, lo_min1 = 999, lo_max1 = 0;
    int lo_run2 = 0, pulses2 = 0, busy2 = 0, overlap2 = 0;

    always @(negedge clk) begin
        if (latch1 && !latch1_q) begin
            pulses1 = 0;
            lo_min1 = 999;
            lo_max1 = 0;
        end
        if (latch1) latch_run1++;
        else if (latch_run1 != 0) begin
            latch_w1   = latch_run1;
            latch_run1 = 0;
        end
        if (!sclk1) lo_run1++;
        else if (lo_run1 != 0) begin
            pulses1++;
            if (lo_run1 < lo_min1) lo_min1 = lo_run1;
            if (lo_run1 > lo_max1) lo_max1 = lo_run1;
            lo_run1 = 0;
        end
        latch1_q = latch1;

        if (latch2 && !latch2_q) begin
            if (busy2 != 0) overlap2++;
            busy2   = 1;
            pulses2 = 0;
        end
        if (valid2) busy2 = 0;
        if (!sclk2) lo_run2++;
        else if (lo_run2 != 0) begin
            pulses2++;
            lo_run2 = 0;
        end
        latch2_q = latch2;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (valid1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] bits,
                             input logic [11:0] exp, input string tag);
        bit ok;
        pad1 = bits;
        wait_valid(ok);
        check({tag, "_timeout"}, 32'(ok), 32'd1);
        check(tag, 32'(state1), 32'(exp));
    endtask

    logic [15:0] pat_bits [7] = '{16'hFEEF, 16'hFF7F, 16'h0FFF,
                                  16'hFFFE, 16'hF7FF, 16'h3555,
                                  16'hCAAA};
    logic [11:0] pat_exp  [7] = '{12'hEEF, 12'hF7F, 12'hFFF,
                                  12'hFFE, 12'h7FF, 12'h555,
                                  12'hAAA};
    int fast_valid_at [3] = '{153, 303, 453};

    initial begin
        int  n;
        int  k;
        int  falls;
        bit  ok;
        logic prev;

        repeat (3) @(negedge clk);
        check("rst_state", 32'(state1), 32'hFFF);
        check("rst_sclk", 32'(sclk1), 32'd1);
        check("rst_latch", 32'(latch1), 32'd0);
        check("rst_valid", 32'(valid1), 32'd0);

        reset = 1'b0;
        n = 0;
        while (!latch1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("first_latch", n, P);

        wait_valid(ok);
        check("f1_timeout", 32'(ok), 32'd1);
        check("f1_state", 32'(state1), 32'hFFF);
        check("f1_latch_w", latch_w1, L);
        check("f1_pulses", pulses1, 16);
        check("f1_low_min", lo_min1, H);
        check("f1_low_max", lo_max1, H);
        @(negedge clk);
        check("f1_valid_w", 32'(valid1), 32'd0);

        for (int i = 0; i < 7; i++)
            run_frame(pat_bits[i], pat_exp[i], $sformatf("pat%0d", i));
        check("pat_pulses", pulses1, 16);

        run_frame(16'hFEEF, 12'hEEF, "pre_rst");
        n = 0;
        while (!latch1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        falls = 0;
        prev  = sclk1;
        n = 0;
        while (falls < 8 && n < 1000) begin
            @(negedge clk);
            n++;
            if (prev && !sclk1) falls++;
            prev = sclk1;
        end
        check("bit7_reached", falls, 8);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state1), 32'hFFF);
        check("mid_rst_sclk", 32'(sclk1), 32'd1);
        check("mid_rst_latch", 32'(latch1), 32'd0);
        check("mid_rst_valid", 32'(valid1), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!valid1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_valid_delay", n, P + FRAME);
        check("rst_new_state", 32'(state1), 32'hEEF);

        @(negedge clk);
        reset2 = 1'b0;
        n = 0;
        k = 0;
        while (k < 3 && n < 1000) begin
            @(negedge clk);
            n++;
            if (valid2) begin
                check($sformatf("fast_t%0d", k), n, fast_valid_at[k]);
                check($sformatf("fast_pulses%0d", k), pulses2, 16);
                check($sformatf("fast_state%0d", k), 32'(state2), 32'hA5C);
                k++;
            end
        end
        check("fast_frames", k, 3);
        check("fast_overlap", overlap2, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
